dcache_ctrl: RTL

//   Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage
//   and the off-chip data memory. Replaces the direct MEM-stage access to data memory.

---
 rtl/dcache_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache between the CPU MEM stage and line-wide data memory
//   clk_i, rst_i (async, active-high)
//   p1_*  : CPU side; load/store request, word address, store data, load data, stall
//   mem_* : memory side; line request held until the one-cycle mem_ack_i, line in/out data
module dcache_ctrl #(
  parameter int INDEX_W = 5,
  parameter int OFFS_W  = 5,
  parameter int ADDR_W  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    p1_req_i,
  input  logic                    p1_write_i,
  input  logic [ADDR_W-1:0]       p1_addr_i,
  input  logic [31:0]             p1_data_i,
  output logic [31:0]             p1_data_o,
  output logic                    p1_stall_o,
  output logic                    mem_enable_o,
  output logic                    mem_write_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [(8<<OFFS_W)-1:0]  mem_data_o,
  input  logic [(8<<OFFS_W)-1:0]  mem_data_i,
  input  logic                    mem_ack_i
);
  localparam int LINES  = 1 << INDEX_W;
  localparam int TAG_W  = ADDR_W - INDEX_W - OFFS_W;
  localparam int LINE_W = 8 << OFFS_W;
  localparam int WORD_W = OFFS_W - 2;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t                state;
  logic [LINES-1:0]      valid, dirty;
  logic [TAG_W-1:0]      tags  [LINES];
  logic [LINE_W-1:0]     lines [LINES];
  logic [TAG_W-1:0]      miss_tag;
  logic [INDEX_W-1:0]    miss_idx;
  logic [TAG_W-1:0]      a_tag;
  logic [INDEX_W-1:0]    a_idx;
  logic [WORD_W-1:0]     a_word;
  logic                  hit, victim_dirty;
  assign a_tag        = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign a_idx        = p1_addr_i[OFFS_W +: INDEX_W];
  assign a_word       = p1_addr_i[2 +: WORD_W];
  assign hit          = p1_req_i & valid[a_idx] & (tags[a_idx] == a_tag) & (state == IDLE);
  assign victim_dirty = valid[a_idx] & dirty[a_idx];
  assign p1_stall_o   = p1_req_i & !hit;
  assign p1_data_o    = (hit & !p1_write_i) ? lines[a_idx][{a_word, 5'd0} +: 32] : 32'd0;
  // Control state and registered memory-side outputs; reset aborts any miss at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      miss_tag     <= '0;
      miss_idx     <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit & p1_write_i) dirty[a_idx] <= 1'b1;
          else if (p1_req_i & !hit) begin
            miss_tag     <= a_tag;
            miss_idx     <= a_idx;
            mem_enable_o <= 1'b1;
            mem_write_o  <= victim_dirty;
            mem_addr_o   <= victim_dirty ? {tags[a_idx], a_idx, {OFFS_W{1'b0}}} : {a_tag, a_idx, {OFFS_W{1'b0}}};
            if (victim_dirty) mem_data_o <= lines[a_idx];
            state        <= victim_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          dirty[miss_idx] <= 1'b0;
          mem_write_o     <= 1'b0;
          mem_addr_o      <= {miss_tag, miss_idx, {OFFS_W{1'b0}}};
          state           <= REFILL;
        end
        REFILL: if (mem_ack_i) begin
          valid[miss_idx] <= 1'b1;
          dirty[miss_idx] <= 1'b0;
          mem_enable_o    <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Tag/data arrays are not reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (hit & p1_write_i) lines[a_idx][{a_word, 5'd0} +: 32] <= p1_data_i;
    if ((state == REFILL) & mem_ack_i) begin
      lines[miss_idx] <= mem_data_i;
      tags[miss_idx]  <= miss_tag;
    end
  end
endmodule
